// File: rtl/fetch_pc_unit_pkg.sv
// Shared types for the instruction-fetch stage:
// FSM states, redirect sources, output-buffer bundle.
package fetch_pc_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    // Declared in descending redirect priority.
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_BR   = 2'd1,
        RD_JR   = 2'd2,
        RD_JMP  = 2'd3
    } redir_src_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } if_buf_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Redirect target mux: branch > jr > jump.
// Ports: redirect request inputs in; redirect flag and raw target out.
module fetch_pc_unit_next_pc_sel
    import fetch_pc_unit_pkg::*;
(
    input  logic        br_taken,
    input  logic [31:0] br_pc4,
    input  logic [31:0] br_offset,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    output logic        redirect,
    output logic [31:0] target
);

    redir_src_t  src;
    logic [31:0] br_target;

    // Word offset scaled to bytes; wraps mod 2^32.
    assign br_target = br_pc4 + (br_offset << 2);

    always_comb begin
        src = RD_NONE;
        if (br_taken) begin
            src = RD_BR;
        end else if (jr_valid) begin
            src = RD_JR;
        end else if (jmp_valid) begin
            src = RD_JMP;
        end
    end

    always_comb begin
        target = 32'h0;
        unique case (src)
            RD_BR:   target = br_target;
            RD_JR:   target = jr_target;
            RD_JMP:  target = jmp_target;
            default: target = 32'h0;
        endcase
    end

    assign redirect = (src != RD_NONE);

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, one-outstanding imem reads,
// 1-entry valid/ready buffer toward decode.
// Ports: clk/rst; br_*/jmp_*/jr_* redirects; imem_* request
// and response; if_* decode buffer with id_ready; misalign pulse.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_taken,
    input  logic [31:0] br_pc4,
    input  logic [31:0] br_offset,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    input  logic        id_ready,
    output logic        misalign
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n, pc_plus4;
    logic         kill, kill_n;
    logic         valid_n, mis_n;
    if_buf_t      buf_q, buf_n;
    logic         redirect, accept;
    logic [31:0]  target;

    fetch_pc_unit_next_pc_sel u_sel (
        .br_taken   (br_taken),
        .br_pc4     (br_pc4),
        .br_offset  (br_offset),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .jr_valid   (jr_valid),
        .jr_target  (jr_target),
        .redirect   (redirect),
        .target     (target)
    );

    assign pc_plus4  = pc + 32'd4;
    assign imem_req  = (state == ST_REQ);
    assign imem_addr = pc;
    assign accept    = imem_req & imem_ready;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        kill_n  = kill;
        valid_n = if_valid;
        buf_n   = buf_q;
        mis_n   = 1'b0;
        unique case (state)
            ST_REQ: begin
                if (accept) state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (kill) begin
                        kill_n  = 1'b0;
                        state_n = ST_REQ;
                    end else begin
                        buf_n   = '{instr: imem_rdata,
                                    pc:    pc,
                                    pc4:   pc_plus4};
                        valid_n = 1'b1;
                        pc_n    = pc_plus4;
                        state_n = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (id_ready) begin
                    valid_n = 1'b0;
                    state_n = ST_REQ;
                end
            end
            default: state_n = ST_REQ;
        endcase

        // Redirect overrides everything; a read still in flight
        // must be drained and its data thrown away via kill.
        if (redirect) begin
            pc_n    = word_align(target);
            valid_n = 1'b0;
            buf_n   = buf_q;
            mis_n   = |target[1:0];
            if ((state == ST_WAIT && !imem_rvalid) || accept) begin
                kill_n  = 1'b1;
                state_n = ST_WAIT;
            end else begin
                kill_n  = 1'b0;
                state_n = ST_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_REQ;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            if_valid <= 1'b0;
            buf_q    <= '0;
            misalign <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            kill     <= kill_n;
            if_valid <= valid_n;
            buf_q    <= buf_n;
            misalign <= mis_n;
        end
    end

    assign if_instr = buf_q.instr;
    assign if_pc    = buf_q.pc;
    assign if_pc4   = buf_q.pc4;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random
// redirects/back-pressure against a next-PC scoreboard.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_taken = 1'b0;
    logic [31:0] br_pc4 = '0;
    logic [31:0] br_offset = '0;
    logic        jmp_valid = 1'b0;
    logic [31:0] jmp_target = '0;
    logic        jr_valid = 1'b0;
    logic [31:0] jr_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc4;
    logic        id_ready = 1'b1;
    logic        misalign;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk        (clk),
        .rst        (rst),
        .br_taken   (br_taken),
        .br_pc4     (br_pc4),
        .br_offset  (br_offset),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .jr_valid   (jr_valid),
        .jr_target  (jr_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_pc4     (if_pc4),
        .id_ready   (id_ready),
        .misalign   (misalign)
    );

    int checks = 0;
    int failures = 0;

    // Memory: word at A reads as A^K, response lat+1 cycles
    // after acceptance; junk on rdata otherwise.
    bit          stall = 1'b0;
    bit          rnd = 1'b0;
    int          lat = 0;
    bit          pend = 1'b0;
    bit          acc_drv = 1'b0;
    bit          rv_drv = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    logic [31:0] acc_addr = '0;

    always @(negedge clk) begin
        if (rv_drv) pend = 1'b0;
        if (acc_drv) begin
            pend  = 1'b1;
            paddr = acc_addr;
            cnt   = lat;
        end
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend) begin
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = paddr ^ K;
            end else begin
                cnt--;
            end
        end
        imem_ready = stall ? 1'b0 :
                     (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        acc_drv  = imem_req & imem_ready & !rst;
        acc_addr = imem_addr;
        rv_drv   = imem_rvalid;
    end

    // Reference model: next PC decode should see, misalign.
    logic [31:0] exp_pc = RPC;
    bit          exp_mis = 1'b0;
    int          cyc_n = 0;
    int          ndel = 0;
    int          del_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic        p_req;
        logic [31:0] p_addr;
        logic [31:0] t;
        bit          p_rd, p_rst, hold;
        p_req  = imem_req;
        p_addr = imem_addr;
        p_rst  = rst;
        p_rd   = br_taken | jr_valid | jmp_valid;
        if (!p_rst && !p_rd && if_valid && id_ready) begin
            chk("if_pc", if_pc, exp_pc);
            chk("if_instr", if_instr, exp_pc ^ K);
            chk("if_pc4", if_pc4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            ndel++;
            del_q.push_back(cyc_n);
        end
        exp_mis = 1'b0;
        if (p_rst) begin
            exp_pc = RPC;
        end else if (p_rd) begin
            if (br_taken) t = br_pc4 + br_offset * 4;
            else if (jr_valid) t = jr_target;
            else t = jmp_target;
            exp_pc  = t & 32'hFFFF_FFFC;
            exp_mis = (t % 4) != 0;
        end
        @(posedge clk);
        hold = p_req && !acc_drv && !p_rd && !p_rst;
        #1;
        cyc_n++;
        chk("misalign", 32'(misalign), 32'(exp_mis));
        if (hold) begin
            chk("req_hold", 32'(imem_req), 32'd1);
            chk("addr_hold", imem_addr, p_addr);
        end
        br_taken  = 1'b0;
        jr_valid  = 1'b0;
        jmp_valid = 1'b0;
    endtask

    task automatic run_del(input int n, input int budget,
                           input string tag);
        int tgt;
        int k;
        tgt = ndel + n;
        k = 0;
        while (ndel < tgt && k < budget) begin
            cyc();
            k++;
        end
        chk(tag, 32'(ndel), 32'(tgt));
    endtask

    task automatic to_wait(input string tag);
        int k;
        k = 0;
        while (!(imem_req == 1'b0 && if_valid == 1'b0) && k < 40) begin
            cyc();
            k++;
        end
        chk(tag, {30'b0, imem_req, if_valid}, 32'd0);
    endtask

    initial begin
        int r0;
        int k;
        // 1: reset state, then zero-wait streaming
        cyc();
        cyc();
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_pc4", if_pc4, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd1);
        chk("rst_addr", imem_addr, RPC);
        rst = 1'b0;
        r0 = cyc_n;
        del_q.delete();
        run_del(3, 20, "t1_count");
        chk("t1_first", 32'(del_q[0] - r0), 32'd2);
        chk("t1_gap1", 32'(del_q[1] - del_q[0]), 32'd3);
        chk("t1_gap2", 32'(del_q[2] - del_q[1]), 32'd3);

        // 2: imem_ready low 4 cycles
        stall = 1'b1;
        k = 0;
        while (imem_req !== 1'b1 && k < 20) begin
            cyc();
            k++;
        end
        repeat (4) begin
            chk("t2_req", 32'(imem_req), 32'd1);
            chk("t2_addr", imem_addr, exp_pc);
            cyc();
        end
        stall = 1'b0;
        run_del(2, 20, "t2_count");

        // 3: branch while a read is outstanding
        lat = 3;
        to_wait("t3_wait");
        br_taken  = 1'b1;
        br_pc4    = 32'h0000_3010;
        br_offset = 32'hFFFF_FFFC;
        cyc();
        chk("t3_killwait", 32'(imem_req), 32'd0);
        lat = 0;
        run_del(1, 30, "t3_count");

        // 4: branch beats jump; misaligned jr
        br_taken   = 1'b1;
        br_pc4     = 32'h0000_4100;
        br_offset  = 32'h0000_0010;
        jmp_valid  = 1'b1;
        jmp_target = 32'h0000_4000;
        cyc();
        run_del(1, 30, "t4_br_count");
        jr_valid  = 1'b1;
        jr_target = 32'h0000_5002;
        cyc();
        chk("t4_mis", 32'(misalign), 32'd1);
        cyc();
        chk("t4_mis_clr", 32'(misalign), 32'd0);
        run_del(1, 30, "t4_jr_count");
        jmp_valid  = 1'b1;
        jmp_target = 32'hFFFF_FFFC;
        cyc();
        run_del(2, 30, "t4_wrap_count");

        // 5: decode stalls in HOLD
        id_ready = 1'b0;
        k = 0;
        while (if_valid !== 1'b1 && k < 20) begin
            cyc();
            k++;
        end
        repeat (10) begin
            chk("t5_valid", 32'(if_valid), 32'd1);
            chk("t5_pc", if_pc, exp_pc);
            chk("t5_instr", if_instr, exp_pc ^ K);
            chk("t5_req", 32'(imem_req), 32'd0);
            cyc();
        end
        id_ready = 1'b1;
        cyc();
        chk("t5_nextreq", 32'(imem_req), 32'd1);
        chk("t5_nextaddr", imem_addr, exp_pc);

        // 6: reset during WAIT, stale response afterwards
        lat = 4;
        to_wait("t6_wait");
        rst   = 1'b1;
        stall = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (6) begin
            chk("t6_valid", 32'(if_valid), 32'd0);
            chk("t6_req", 32'(imem_req), 32'd1);
            chk("t6_addr", imem_addr, RPC);
            cyc();
        end
        stall = 1'b0;
        lat = 0;
        run_del(1, 30, "t6_count");

        // 7: random back-pressure, latency and redirects
        rnd = 1'b1;
        repeat (500) begin
            id_ready = ($urandom_range(0, 3) != 0);
            lat = $urandom_range(0, 3);
            k = $urandom_range(0, 15);
            if (k == 0 || k == 3) begin
                br_taken  = 1'b1;
                br_pc4    = $urandom;
                r0        = $urandom;
                br_offset = {{16{r0[15]}}, r0[15:0]};
            end
            if (k == 1 || k == 3) begin
                jr_valid  = 1'b1;
                jr_target = $urandom;
            end
            if (k == 2 || k == 3) begin
                jmp_valid  = 1'b1;
                jmp_target = $urandom & 32'hFFFF_FFFC;
            end
            cyc();
        end
        rnd = 1'b0;
        lat = 0;
        id_ready = 1'b1;
        run_del(1, 40, "t7_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
